spi_slave_gen: RTL and testbench
================================

// Module: spi_slave_gen
// PURPOSE
// - Parametrised SPI slave, successor to the fixed 10-bit slave; sits between an external SPI master and the single-port RAM.
// - Deserialises frames of (2-bit command + DATA_W payload) from MOSI and hands them to the RAM as rx_data/rx_valid.
// - Serialises RAM read data back on MISO through a valid/ready handshake.
// - Adds over the previous generation: frame-abort detection, a read-data timeout and a single-cycle rx_valid pulse.
// PARAMETERS
// - DATA_W      8    payload/read-data width; frame length F = DATA_W+2
// - TX_TIMEOUT  16   max cycles in WAIT_TX before abort (>=1)
// PORTS
// - clk        in   1         clock; all logic on posedge; SPI bits sampled/driven 1 per clk
// - rst_n      in   1         reset, synchronous, active-low
// - ss_n       in   1         slave select, active-low
// - mosi       in   1         serial in, MSB first
// - miso       out  1         serial out, MSB first
// - rx_data    out  DATA_W+2  received frame {cmd[1:0], payload}
// - rx_valid   out  1         1-cycle pulse: rx_data is new
// - tx_data    in   DATA_W    read data from RAM
// - tx_valid   in   1         tx_data valid
// - tx_ready   out  1         slave can accept tx_data (high only in WAIT_TX)
// - frame_err  out  1         1-cycle pulse: frame aborted or rejected
// - busy       out  1         registered; 1 whenever state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; miso, rx_valid, rx_data, tx_ready, frame_err, busy = 0; rd_addr_seen = 0. Reset mid-frame aborts silently (no frame_err).
// - States: IDLE, RX, WAIT_TX, TX, HOLD.
// - IDLE
//   - ss_n=0 sampled -> RX, bit counter = F.
//   - ss_n=1 -> stay IDLE.
// - RX
//   - Each edge with ss_n=0: shift mosi into sreg (MSB first), counter-1.
//   - The F bits are taken on F consecutive edges, the first being the first edge with state==RX.
//   - On the F-th sample, cmd = first two bits:
//     - 00 / 01 (write addr / write data): rx_data <= frame, rx_valid=1 next cycle, -> HOLD.
//     - 10 (read addr): rx_data, rx_valid as for write; rd_addr_seen <= 1; -> HOLD.
//     - 11 with rd_addr_seen=1: rx_data, rx_valid as for write; -> WAIT_TX.
//     - 11 with rd_addr_seen=0: no rx_valid; rx_data unchanged; frame_err pulse; -> HOLD.
// - WAIT_TX
//   - tx_ready=1.
//   - tx_valid&&tx_ready on an edge: load tx_data into shift reg; miso <= tx_data[DATA_W-1]; -> TX, counter = DATA_W-1.
//   - TX_TIMEOUT consecutive cycles in WAIT_TX without a transfer: frame_err pulse, -> HOLD; rd_addr_seen kept.
//   - tx_valid outside WAIT_TX is ignored.
// - TX
//   - Each edge: miso <= next lower bit, counter-1.
//   - Each bit is held exactly 1 cycle; bit DATA_W-1 is driven first.
//   - After bit 0 has been held 1 cycle: -> HOLD, rd_addr_seen <= 0, miso <= 0.
// - HOLD
//   - miso=0; mosi ignored.
//   - ss_n=1 -> IDLE. No error.
// - ss_n=1 sampled in RX, WAIT_TX or TX: abort.
//   - frame_err pulse; -> IDLE; no rx_valid; miso <= 0; rd_addr_seen unchanged.
//   - An ss_n rise on the edge that would take the last RX bit counts as an abort: that bit is not sampled.
// - rx_data holds its value until the next accepted frame.
// - rx_valid and frame_err are never high in the same cycle.
// - miso = 0 in all states except TX.
// - Back-to-back frames: ss_n low again the cycle after IDLE is entered starts a new frame.
// TESTING (DATA_W=8, F=10, TX_TIMEOUT=16)
// - Reset: rst_n=0 for 2 cycles mid-RX -> all outputs 0, state IDLE, no frame_err.
// - Write addr: ss_n=0, mosi=00_1010_0101 -> rx_data=10'h0A5, rx_valid high 1 cycle, then HOLD; ss_n=1 -> IDLE.
// - Read sequence:
//   - Frame 10_0000_0011 -> rx_valid; rd_addr_seen set.
//   - Frame 11_xxxx_xxxx -> rx_valid, tx_ready=1.
//   - Drive tx_valid with tx_data=8'hC3 -> miso = 1,1,0,0,0,0,1,1 on 8 consecutive cycles.
//   - Then miso=0 and rd_addr_seen clear.
// - Read data without prior read addr: frame 11_0000_0000 -> frame_err pulse, no rx_valid, tx_ready stays 0.
// - Early abort: ss_n=1 after 6 bits -> frame_err 1 cycle, IDLE, rx_data unchanged.
// - Timeout: valid read-data frame, tx_valid held 0 -> frame_err after exactly 16 cycles in WAIT_TX; tx_ready drops.

Source files
------------

// File: rtl/spi_slave_gen.sv
// SPI slave: shifts in {cmd[1:0], payload} frames and hands them to the RAM. It also shifts RAM read data out on MISO.
// Latency: rx_valid one cycle after the last MOSI bit; MISO MSB one cycle after the tx handshake; tx_ready only in WAIT_TX.
module spi_slave_gen #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic [DATA_W+1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int F  = DATA_W + 2;
  localparam int CW = $clog2(F + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, HOLD} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_bit_cnt;
  logic [TW-1:0]     r_to_cnt;
  logic [F-2:0]      r_sreg;
  logic [DATA_W-1:0] r_tx_sreg;
  logic              r_rd_seen;
  logic              r_miso, r_rx_valid, r_frame_err, r_busy;
  logic [F-1:0]      r_rx_data;

  logic [F-1:0] w_frame;
  logic [1:0]   w_cmd;
  logic         w_last_bit, w_rd_reject, w_xfer, w_timeout, w_abort, w_tx_done;

  // The final bit is taken straight from MOSI on the edge that completes the frame.
  assign w_frame     = {r_sreg, i_mosi};
  assign w_cmd       = w_frame[F-1:F-2];
  assign w_last_bit  = (r_state == RX) && !i_ss_n && (r_bit_cnt == CW'(1));
  assign w_rd_reject = w_last_bit && (w_cmd == 2'b11) && !r_rd_seen;
  assign w_xfer      = (r_state == WAIT_TX) && !i_ss_n && i_tx_valid;
  assign w_timeout   = (r_state == WAIT_TX) && !i_ss_n && !i_tx_valid &&
                       (r_to_cnt == TW'(TX_TIMEOUT - 1));
  assign w_tx_done   = (r_state == TX) && !i_ss_n && (r_bit_cnt == '0);
  assign w_abort     = i_ss_n && ((r_state == RX) || (r_state == WAIT_TX) || (r_state == TX));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!i_ss_n) w_next = RX;
      RX: begin
        if (i_ss_n) w_next = IDLE;
        else if (w_last_bit) w_next = (w_cmd == 2'b11 && r_rd_seen) ? WAIT_TX : HOLD;
      end
      WAIT_TX: begin
        if (i_ss_n) w_next = IDLE;
        else if (i_tx_valid) w_next = TX;
        else if (w_timeout) w_next = HOLD;
      end
      TX: begin
        if (i_ss_n) w_next = IDLE;
        else if (r_bit_cnt == '0) w_next = HOLD;
      end
      HOLD:    if (i_ss_n) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_sreg      <= '0;
      r_tx_sreg   <= '0;
      r_rd_seen   <= 1'b0;
      r_miso      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != IDLE);
      r_rx_valid  <= w_last_bit && !w_rd_reject;
      r_frame_err <= w_abort || w_timeout || w_rd_reject;
      r_to_cnt    <= ((r_state == WAIT_TX) && !i_ss_n && !i_tx_valid) ? r_to_cnt + TW'(1) : '0;

      if (r_state == IDLE && !i_ss_n) r_bit_cnt <= CW'(F);
      else if (r_state == RX && !i_ss_n) begin
        r_bit_cnt <= r_bit_cnt - CW'(1);
        r_sreg    <= w_frame[F-2:0];
      end else if (w_xfer) r_bit_cnt <= CW'(DATA_W - 1);
      else if (r_state == TX && r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - CW'(1);

      if (w_last_bit && !w_rd_reject) r_rx_data <= w_frame;

      if (w_last_bit && w_cmd == 2'b10) r_rd_seen <= 1'b1;
      else if (w_tx_done) r_rd_seen <= 1'b0;

      if (w_xfer) begin
        r_miso    <= i_tx_data[DATA_W-1];
        r_tx_sreg <= {i_tx_data[DATA_W-2:0], 1'b0};
      end else if (r_state == TX && w_next == TX) begin
        r_miso    <= r_tx_sreg[DATA_W-1];
        r_tx_sreg <= {r_tx_sreg[DATA_W-2:0], 1'b0};
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign o_miso      = r_miso;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_tx_ready  = (r_state == WAIT_TX);
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen (DATA_W=8, TX_TIMEOUT=16); inputs change and outputs are sampled 1ns after posedge.
module tb_spi_slave_gen;

  logic       clk = 1'b0;
  logic       rst_n, ss_n, mosi, miso, rx_valid, tx_valid, tx_ready, frame_err, busy;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(8), .TX_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_ss_n(ss_n), .i_mosi(mosi), .o_miso(miso),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_tx_data(tx_data),
    .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .o_frame_err(frame_err), .o_busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lowers ss_n, waits the IDLE->RX edge, then presents the top n bits of f MSB first.
  task automatic send_bits(input logic [9:0] f, input int n);
    ss_n = 1'b0;
    tick();
    for (int i = 9; i > 9 - n; i--) begin
      mosi = f[i];
      tick();
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_val("reset_outputs", {miso, rx_valid, rx_data, tx_ready, frame_err, busy}, 32'h0);

    // Reset in the middle of a frame: silent, back to idle.
    send_bits(10'h3FF, 4);
    check_val("mid_rx_busy", busy, 1);
    rst_n = 1'b0; ss_n = 1'b1;
    tick();
    check_val("rst_cyc1_err", frame_err, 0);
    tick();
    check_val("rst_cyc2_outs", {miso, rx_valid, rx_data, tx_ready, frame_err, busy}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_val("rst_release_err", frame_err, 0);

    // Write address, with tx_valid asserted where it must be ignored.
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_bits(10'b00_1010_0101, 10);
    tx_valid = 1'b0;
    check_val("wr_rx_valid", rx_valid, 1);
    check_val("wr_rx_data", rx_data, 10'h0A5);
    check_val("wr_err", frame_err, 0);
    check_val("wr_hold_busy", busy, 1);
    tick();
    check_val("wr_valid_pulse", rx_valid, 0);
    check_val("wr_miso_hold", miso, 0);
    check_val("wr_tx_ready", tx_ready, 0);
    end_frame();
    check_val("wr_idle_busy", busy, 0);
    check_val("wr_idle_err", frame_err, 0);

    // Read-data command with no preceding read address is rejected.
    send_bits(10'b11_0000_0000, 10);
    check_val("rej_err", frame_err, 1);
    check_val("rej_valid", rx_valid, 0);
    check_val("rej_rx_data", rx_data, 10'h0A5);
    check_val("rej_tx_ready", tx_ready, 0);
    tick();
    check_val("rej_err_pulse", frame_err, 0);
    end_frame();

    // Read sequence.
    send_bits(10'b10_0000_0011, 10);
    check_val("rda_valid", rx_valid, 1);
    check_val("rda_data", rx_data, 10'h203);
    end_frame();
    send_bits(10'b11_1111_0000, 10);
    check_val("rdd_valid", rx_valid, 1);
    check_val("rdd_data", rx_data, 10'h3F0);
    check_val("rdd_tx_ready", tx_ready, 1);
    tx_valid = 1'b1; tx_data = c3;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    check_val("tx_ready_in_tx", tx_ready, 0);
    for (int i = 7; i >= 0; i--) begin
      check_val($sformatf("miso_bit%0d", i), miso, c3[i]);
      tick();
    end
    check_val("tx_done_miso", miso, 0);
    check_val("tx_done_busy", busy, 1);
    check_val("tx_done_err", frame_err, 0);
    end_frame();

    // Read address was consumed by the transfer.
    send_bits(10'b11_0000_0001, 10);
    check_val("rd_seen_clr_err", frame_err, 1);
    check_val("rd_seen_clr_valid", rx_valid, 0);
    end_frame();

    // Early abort after 6 bits.
    send_bits(10'b01_0101_0101, 6);
    ss_n = 1'b1;
    tick();
    check_val("abort6_err", frame_err, 1);
    check_val("abort6_valid", rx_valid, 0);
    check_val("abort6_busy", busy, 0);
    check_val("abort6_rx_data", rx_data, 10'h3F0);
    tick();
    check_val("abort6_err_pulse", frame_err, 0);

    // ss_n rising on the edge that would take the last bit.
    send_bits(10'b01_1111_1111, 9);
    ss_n = 1'b1;
    tick();
    check_val("abort9_err", frame_err, 1);
    check_val("abort9_valid", rx_valid, 0);
    check_val("abort9_rx_data", rx_data, 10'h3F0);
    tick();

    // Timeout in WAIT_TX.
    send_bits(10'b10_0101_0101, 10);
    end_frame();
    send_bits(10'b11_1010_1010, 10);
    check_val("to_valid", rx_valid, 1);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 16; k++) begin
        if (tx_ready !== 1'b1 || frame_err !== 1'b0) bad++;
        tick();
      end
      check_val("to_wait_16_cycles", bad, 0);
    end
    check_val("to_err", frame_err, 1);
    check_val("to_tx_ready", tx_ready, 0);
    check_val("to_hold_busy", busy, 1);
    tick();
    check_val("to_err_pulse", frame_err, 0);
    end_frame();

    // Read address survives a timeout; then abort from WAIT_TX.
    send_bits(10'b11_0000_1111, 10);
    check_val("kept_rd_valid", rx_valid, 1);
    check_val("kept_rd_ready", tx_ready, 1);
    ss_n = 1'b1;
    tick();
    check_val("wait_abort_err", frame_err, 1);
    check_val("wait_abort_busy", busy, 0);
    check_val("wait_abort_miso", miso, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
